// File: rtl/rv32_data_mem_responder_if.sv
// Memory-stage request/response bundle: request types plus the handshake interface.
// The requester drives data_request; the responder returns request_done, read_data and misaligned.
package rv32_mem_pkg;

    typedef enum logic [3:0] {
        MEM_NOP,
        MEM_LB,
        MEM_LH,
        MEM_LW,
        MEM_LBU,
        MEM_LHU,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_op_t;

    typedef struct packed {
        logic [31:0] addr;
        mem_op_t     op;
        logic [31:0] data;
    } memory_request_t;

endpackage

interface rv32_data_mem_responder_if;
    import rv32_mem_pkg::*;

    memory_request_t data_request;
    logic            request_done;
    logic [31:0]     read_data;
    logic            misaligned;

    modport master (
        output data_request,
        input  request_done,
        input  read_data,
        input  misaligned
    );

    modport slave (
        input  data_request,
        output request_done,
        output read_data,
        output misaligned
    );
endinterface

// File: rtl/rv32_data_mem_responder.sv
// Data-memory slave: one load/store per transaction, request_done LATENCY cycles after acceptance.
// No backpressure; a non-NOP request is taken in IDLE and ignored elsewhere, so throughput is one per LATENCY+1.
module rv32_data_mem_responder
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic clk,
    input  logic resetn,
    rv32_data_mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [AW+1:0]   addr_q;
    mem_op_t         op_q;
    logic [31:0]     data_q;
    logic            done_q;
    logic            misaligned_q;
    logic [31:0]     read_data_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            enter_resp;
    logic [AW+1:0]   rd_addr;
    mem_op_t         rd_op;
    logic            wr_en;
    logic [3:0]      wr_be;
    logic [31:0]     wr_data;

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] a);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: is_misaligned = a[0];
            MEM_LW, MEM_SW:          is_misaligned = (a != 2'b00);
            default:                 is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input mem_op_t op);
        is_load = (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
                  (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic [31:0] load_extend(input mem_op_t op, input logic [31:0] word,
                                                input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_LB:  load_extend = {{24{b[7]}}, b};
            MEM_LBU: load_extend = {24'b0, b};
            MEM_LH:  load_extend = {{16{h[15]}}, h};
            MEM_LHU: load_extend = {16'b0, h};
            default: load_extend = word;
        endcase
    endfunction

    // The synchronous array read happens on the edge entering RESP; with LATENCY=1 that
    // edge is the accept edge, so the live request must address the array.
    always_comb begin
        accept     = (state == IDLE) && (bus.data_request.op != MEM_NOP);
        enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));
        rd_addr    = (state == IDLE) ? bus.data_request.addr[AW+1:0] : addr_q;
        rd_op      = (state == IDLE) ? bus.data_request.op : op_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            addr_q       <= '0;
            op_q         <= MEM_NOP;
            data_q       <= 32'd0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            read_data_q  <= 32'd0;
        end else begin
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= bus.data_request.addr[AW+1:0];
                        op_q   <= bus.data_request.op;
                        data_q <= bus.data_request.data;
                        cnt    <= 4'(LATENCY - 1);
                        state  <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                done_q <= 1'b1;
                if (is_misaligned(rd_op, rd_addr[1:0])) begin
                    misaligned_q <= 1'b1;
                    read_data_q  <= 32'd0;
                end else if (is_load(rd_op)) begin
                    read_data_q <= load_extend(rd_op, mem[rd_addr[AW+1:2]], rd_addr[1:0]);
                end
            end
        end
    end

    // Store commits on the edge closing RESP; reset in that cycle suppresses it.
    always_comb begin
        wr_en   = (state == RESP) && is_store(op_q) && !is_misaligned(op_q, addr_q[1:0]);
        wr_be   = 4'b0000;
        wr_data = data_q;
        case (op_q)
            MEM_SB: begin
                wr_be   = 4'b0001 << addr_q[1:0];
                wr_data = {4{data_q[7:0]}};
            end
            MEM_SH: begin
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{data_q[15:0]}};
            end
            MEM_SW:  wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign bus.request_done = done_q;
    assign bus.misaligned   = misaligned_q;
    assign bus.read_data    = read_data_q;

endmodule

// File: tb/tb_rv32_data_mem_responder.sv
// Bench for rv32_data_mem_responder: directed requests push expectations, a monitor pops them on request_done.
module tb_rv32_data_mem_responder;
    import rv32_mem_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    rv32_data_mem_responder_if bus();

    rv32_data_mem_responder #(
        .DEPTH_WORDS(4096),
        .LATENCY    (LAT)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rd;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (bus.request_done === 1'b1) begin
                chk("done_single_cycle", {31'b0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(sb.size() + 1), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("misaligned", {31'b0, bus.misaligned}, {31'b0, e.mis});
                    chk("read_data", bus.read_data, e.rd);
                end
            end
            prev_done = bus.request_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Drive one request in IDLE, wait for its completion, return just after the RESP cycle ends.
    task automatic issue(input string name, input mem_op_t op, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_mis,
                         output int done_cyc);
        int   n;
        logic got;
        sb.push_back('{rd: exp_rd, mis: exp_mis});
        bus.data_request = '{addr: a, op: op, data: d};
        n        = 0;
        got      = 1'b0;
        done_cyc = -1;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.request_done === 1'b1) begin
                got      = 1'b1;
                done_cyc = cyc;
            end
        end
        chk({name, "_latency"}, 32'(n), 32'(LAT + 1));
        @(posedge clk);
        #1;
    endtask

    int t0, t1, dn;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn           = 1'b0;
        bus.data_request = '{addr: 32'd0, op: MEM_NOP, data: 32'd0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", {31'b0, bus.request_done}, 32'd0);
        chk("rst_mis", {31'b0, bus.misaligned}, 32'd0);
        chk("rst_rd", bus.read_data, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        issue("sw10", MEM_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, t0);
        issue("lw10", MEM_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, t0);
        issue("lb13", MEM_LB, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, t0);
        issue("lbu13", MEM_LBU, 32'h13, 32'h0, 32'h000000DE, 1'b0, t0);
        issue("lh10", MEM_LH, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, t0);
        issue("lhu12", MEM_LHU, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, t0);
        issue("sb11", MEM_SB, 32'h11, 32'h55, 32'h0000DEAD, 1'b0, t0);
        issue("sh12", MEM_SH, 32'h12, 32'h1234, 32'h0000DEAD, 1'b0, t0);
        issue("lw10_part", MEM_LW, 32'h10, 32'h0, 32'h123455EF, 1'b0, t0);
        issue("lw11_mis", MEM_LW, 32'h11, 32'h0, 32'h0, 1'b1, t0);
        issue("sh13_mis", MEM_SH, 32'h13, 32'hFFFF, 32'h0, 1'b1, t0);
        issue("lw10_kept", MEM_LW, 32'h10, 32'h0, 32'h123455EF, 1'b0, t0);

        issue("sw20", MEM_SW, 32'h20, 32'hCAFEF00D, 32'h123455EF, 1'b0, t0);
        issue("lw20_a", MEM_LW, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, t0);
        issue("lw20_b", MEM_LW, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, t1);
        chk("b2b_spacing", 32'(t1 - t0), 32'(LAT + 1));

        issue("sw4010", MEM_SW, 32'h4010, 32'h0BADC0DE, 32'hCAFEF00D, 1'b0, t0);
        issue("lw10_wrap", MEM_LW, 32'h10, 32'h0, 32'h0BADC0DE, 1'b0, t0);
        issue("lh12_pos", MEM_LH, 32'h12, 32'h0, 32'h00000BAD, 1'b0, t0);
        issue("lb10_neg", MEM_LB, 32'h10, 32'h0, 32'hFFFFFFDE, 1'b0, t0);

        issue("sw30", MEM_SW, 32'h30, 32'hA5A5A5A5, 32'hFFFFFFDE, 1'b0, t0);
        bus.data_request = '{addr: 32'h30, op: MEM_SW, data: 32'h1};
        @(posedge clk);
        #1;
        resetn           = 1'b0;
        bus.data_request = '{addr: 32'h0, op: MEM_NOP, data: 32'h0};
        @(posedge clk);
        @(negedge clk);
        chk("midrst_done", {31'b0, bus.request_done}, 32'd0);
        chk("midrst_mis", {31'b0, bus.misaligned}, 32'd0);
        chk("midrst_rd", bus.read_data, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.request_done === 1'b1) dn++;
        end
        chk("nop_no_done", 32'(dn), 32'd0);
        @(posedge clk);
        #1;
        issue("lw30_after_rst", MEM_LW, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0, t0);
        bus.data_request = '{addr: 32'h0, op: MEM_NOP, data: 32'h0};
        repeat (4) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
